// File: rtl/stdcell_test_pkg.sv
// Shared state encoding and truth-table constants for the standard-cell exhaustive checker.
// Truth-table bit i is the expected cell output when the input vector equals i.
package stdcell_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Y = ~((A&B)|C), Y = ~(A&B), Y = ~A with A as the most significant vector bit
    localparam logic [7:0] TT_AOI21 = 8'h15;
    localparam logic [3:0] TT_NAND2 = 4'h7;
    localparam logic [1:0] TT_INV   = 2'h1;

endpackage

// File: rtl/stdcell_settle_timer.sv
// Settle-window down-counter: load starts a window of SETTLE_CYCLES cycles, and expired
// is high during the last cycle of that window.
module stdcell_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VALUE = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/stdcell_exhaustive_checker.sv
// Walks every input vector of one combinational cell, holds each for a settle window,
// compares the cell output against TRUTH_TABLE and reports the tally over val/rdy.
module stdcell_exhaustive_checker
    import stdcell_test_pkg::*;
#(
    parameter int                    NINPUTS       = 3,
    parameter logic [2**NINPUTS-1:0] TRUTH_TABLE   = TT_AOI21,
    parameter int                    SETTLE_CYCLES = 2,
    parameter bit                    STOP_ON_FAIL  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_val,
    output logic               start_rdy,
    output logic [NINPUTS-1:0] dut_in,
    input  logic               dut_out,
    output logic               busy,
    output logic               done_val,
    input  logic               done_rdy,
    output logic               pass,
    output logic [NINPUTS:0]   fail_count,
    output logic [NINPUTS-1:0] first_fail_vec,
    output logic               first_fail_act
);

    localparam logic [NINPUTS-1:0] VEC_LAST = '1;
    localparam logic [NINPUTS-1:0] VEC_ONE  = NINPUTS'(1);
    localparam logic [NINPUTS:0]   FC_ONE   = (NINPUTS + 1)'(1);

    state_t             state;
    state_t             state_next;
    logic [NINPUTS-1:0] vec;
    logic               settle_expired;
    logic               start_fire;
    logic               sample;
    logic               mismatch;
    logic               finish;
    logic               timer_load;

    assign start_fire = (state == IDLE) && start_val;
    assign sample     = (state == APPLY) && settle_expired;
    assign mismatch   = sample && (dut_out != TRUTH_TABLE[vec]);
    // End of run is an explicit compare on the last vector so the counter never has to wrap
    assign finish     = sample && ((vec == VEC_LAST) || (STOP_ON_FAIL && mismatch));
    assign timer_load = start_fire || (sample && !finish);

    stdcell_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .expired(settle_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_fire) state_next = APPLY;
            APPLY:   if (finish) state_next = DONE;
            DONE:    if (done_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are only cleared by accepting a new start, so they remain readable in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec            <= '0;
            dut_in         <= '0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            first_fail_act <= 1'b0;
        end else if (start_fire) begin
            vec            <= '0;
            dut_in         <= '0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            first_fail_act <= 1'b0;
        end else if (sample) begin
            if (mismatch) begin
                fail_count <= fail_count + FC_ONE;
                if (fail_count == '0) begin
                    first_fail_vec <= vec;
                    first_fail_act <= dut_out;
                end
            end
            if (finish) begin
                dut_in <= '0;
            end else begin
                vec    <= vec + VEC_ONE;
                dut_in <= vec + VEC_ONE;
            end
        end
    end

    assign start_rdy = (state == IDLE);
    assign busy      = (state == APPLY);
    assign done_val  = (state == DONE);
    assign pass      = (fail_count == '0);

endmodule
